fnd_scan_controller: RTL and testbench

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_scan_controller.sv | 126 ++++++++++++
 tb/tb_fnd_scan_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan_controller.sv
// Binary-to-BCD converter (sequential double dabble) feeding a 4-digit multiplexed FND scanner.
// A new result replaces the whole display at once; the scan keeps running during conversion.
module fnd_scan_controller #(
  parameter int CLK_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [13:0] i_value,
  input  logic        i_load,
  output logic        o_busy,
  output logic        o_overflow,
  output logic [1:0]  o_digitSelect,
  output logic [3:0]  o_bcd,
  output logic        o_en
);

  typedef enum logic {IDLE, CONVERT} state_t;

  localparam logic [19:0] PRE_MAX   = 20'(CLK_DIV - 1);
  localparam logic [13:0] VALUE_MAX = 14'd9999;
  localparam logic [3:0]  LAST_ITER = 4'd13;

  state_t      state;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic [3:0]  iter;
  logic [15:0] display;
  logic [19:0] prescale;
  logic [1:0]  digit_idx;

  logic [15:0] bcd_adj;
  logic [15:0] bcd_next;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < 4; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    bcd_next = {bcd_adj[14:0], bin[13]};
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      bin        <= '0;
      bcd        <= '0;
      iter       <= '0;
      display    <= '0;
      o_busy     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_load) begin
            if (i_value > VALUE_MAX) begin
              bin        <= VALUE_MAX;
              o_overflow <= 1'b1;
            end else begin
              bin        <= i_value;
              o_overflow <= 1'b0;
            end
            bcd    <= '0;
            iter   <= '0;
            o_busy <= 1'b1;
            state  <= CONVERT;
          end
        end
        CONVERT: begin
          bcd  <= bcd_next;
          bin  <= {bin[12:0], 1'b0};
          iter <= iter + 4'd1;
          if (iter == LAST_ITER) begin
            display <= bcd_next;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Free-running digit scan, independent of conversions.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prescale  <= '0;
      digit_idx <= '0;
    end else if (prescale == PRE_MAX) begin
      prescale  <= '0;
      digit_idx <= digit_idx + 2'd1;
    end else begin
      prescale  <= prescale + 20'd1;
    end
  end

  assign o_digitSelect = digit_idx;

  // Leading-zero blanking: a digit lights if it or any more significant digit is nonzero.
  always_comb begin
    o_bcd = display[3:0];
    o_en  = 1'b1;
    case (digit_idx)
      2'd0: begin
        o_bcd = display[3:0];
        o_en  = 1'b1;
      end
      2'd1: begin
        o_bcd = display[7:4];
        o_en  = |display[15:4];
      end
      2'd2: begin
        o_bcd = display[11:8];
        o_en  = |display[15:8];
      end
      default: begin
        o_bcd = display[15:12];
        o_en  = |display[15:12];
      end
    endcase
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Scoreboard bench for fnd_scan_controller: loads push expected results, a monitor checks
// completion timing, overflow and every scanned digit against a decimal-arithmetic model.
module tb_fnd_scan_controller;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 10;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [13:0] i_value;
  logic        i_load;
  logic        o_busy;
  logic        o_overflow;
  logic [1:0]  o_digitSelect;
  logic [3:0]  o_bcd;
  logic        o_en;

  fnd_scan_controller #(.CLK_DIV(CLK_DIV)) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_value      (i_value),
    .i_load       (i_load),
    .o_busy       (o_busy),
    .o_overflow   (o_overflow),
    .o_digitSelect(o_digitSelect),
    .o_bcd        (o_bcd),
    .o_en         (o_en)
  );

  always #(PERIOD / 2) clk = ~clk;

  typedef struct {
    int  value;
    bit  ovf;
    time t_cap;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int clamp(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  // Monitor: reference display value, scan position from edge count since reset release.
  initial begin
    int   disp_val = 0;
    int   n_edges  = 0;
    bit   prev_busy = 1'b0;
    int   exp_idx;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (i_reset) begin
        n_edges   = 0;
        disp_val  = 0;
        prev_busy = 1'b0;
        check("reset_busy", 32'(o_busy), 0);
        check("reset_ovf",  32'(o_overflow), 0);
        check("reset_sel",  32'(o_digitSelect), 0);
        check("reset_bcd",  32'(o_bcd), 0);
        check("reset_en",   32'(o_en), 1);
      end else begin
        n_edges++;
        if (prev_busy && !o_busy) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            disp_val = e.value;
            check("busy_cycles", 32'(($time - 1 - e.t_cap) / PERIOD), 14);
            check("done_ovf", 32'(o_overflow), 32'(e.ovf));
          end
        end
        exp_idx = (n_edges / CLK_DIV) % 4;
        check("digit_sel", 32'(o_digitSelect), 32'(exp_idx));
        check("digit_bcd", 32'(o_bcd), 32'((disp_val / pow10(exp_idx)) % 10));
        check("digit_en",  32'(o_en),
              32'((exp_idx == 0) || (disp_val / pow10(exp_idx) != 0)));
        prev_busy = o_busy;
      end
    end
  end

  // Load v; optionally pulse a second load (gv) at busy cycle glitch (1..13, 0 = none),
  // or assert reset at busy cycle rst_at (0 = none). Returns after completion or reset.
  task automatic do_load(input int v, input int glitch, input int gv, input int rst_at,
                         input int idle);
    time t;
    @(negedge clk);
    i_value = 14'(v);
    i_load  = 1'b1;
    @(posedge clk);
    t = $time;
    sb.push_back('{clamp(v), v > 9999, t});
    #1;
    check("busy_rise", 32'(o_busy), 1);
    check("cap_ovf", 32'(o_overflow), 32'(v > 9999));
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      i_load = (c == glitch);
      if (c == glitch) i_value = 14'(gv);
      if (c == rst_at) begin
        i_load  = 1'b0;
        i_reset = 1'b1;
        sb.delete();
        #1;
        check("abort_busy", 32'(o_busy), 0);
        check("abort_ovf",  32'(o_overflow), 0);
        check("abort_sel",  32'(o_digitSelect), 0);
        check("abort_bcd",  32'(o_bcd), 0);
        check("abort_en",   32'(o_en), 1);
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        return;
      end
    end
    @(negedge clk);
    i_load = 1'b0;
    @(posedge clk);
    repeat (idle) @(posedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bounds[11] = '{0, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 16383};
    int v;
    i_reset = 1'b1;
    i_value = '0;
    i_load  = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b0;

    // Scan order and values after a normal load.
    do_load(1234, 0, 0, 0, 17);
    // Leading-zero blanking.
    do_load(7, 0, 0, 0, 17);
    do_load(0, 0, 0, 0, 17);
    do_load(1005, 0, 0, 0, 17);
    // Overflow clamp then clear.
    do_load(12000, 0, 0, 0, 17);
    do_load(42, 0, 0, 0, 17);
    // Load during busy is ignored.
    do_load(5555, 5, 1111, 0, 17);
    do_load(3210, 13, 4444, 0, 5);
    // Reset aborts a conversion, reload right after release.
    do_load(8888, 0, 0, 0, 17);
    do_load(1234, 0, 0, 7, 0);
    do_load(1234, 0, 0, 0, 17);

    foreach (bounds[i]) do_load(bounds[i], 0, 0, 0, 16);

    for (int n = 0; n < 2000; n++) begin
      v = int'($urandom_range(0, 16383));
      if ($urandom_range(0, 3) == 0) v = int'($urandom_range(0, 99));
      do_load(v, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 13)) : 0,
              int'($urandom_range(0, 16383)), 0, int'($urandom_range(0, 3)));
    end

    repeat (20) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
